// File: rtl/sm_regdump.sv
// Debug register dumper: reads CPU debug registers 0..NREGS-1 and streams them over an 8N1 UART line.
// Optional macro SM_REGDUMP_HEX_EN: send each register as 8 ASCII hex chars plus LF instead of 4 raw bytes.
module sm_regdump #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned NREGS   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ADDR_W = 5;
`ifdef SM_REGDUMP_HEX_EN
    localparam int unsigned FRAMES_PER_REG = 9;
`else
    localparam int unsigned FRAMES_PER_REG = 4;
`endif
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NREGS - 1);
    localparam logic [IDX_W-1:0]  BYTE_LAST = IDX_W'(FRAMES_PER_REG - 1);
    localparam logic [3:0]        BIT_STOP  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        LOAD,
        SHIFT,
        NEXT,
        FIN
    } state_t;

    state_t            state, stateNext;
    logic [31:0]       word, wordNext;
    logic [IDX_W-1:0]  byteIdx, byteIdxNext;
    logic [CNT_W-1:0]  bitCnt, bitCntNext;
    logic [3:0]        bitIdx, bitIdxNext;
    logic [8:0]        shifter, shifterNext;
    logic [ADDR_W-1:0] regAddrNext;
    logic              txNext, busyNext, doneNext;
    logic [7:0]        frameByte;

`ifdef SM_REGDUMP_HEX_EN
    logic [3:0] nibble;

    function automatic logic [7:0] hexChar(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

    // Character for the current frame: nibbles MSB first, then a line feed
    always_comb begin
        nibble    = 4'(word >> (5'd28 - {byteIdx[2:0], 2'b00}));
        frameByte = (byteIdx == BYTE_LAST) ? 8'h0A : hexChar(nibble);
    end
`else
    // Byte for the current frame: most significant byte first
    always_comb begin
        frameByte = 8'(word >> (5'd24 - {byteIdx[1:0], 3'b000}));
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            word    <= '0;
            byteIdx <= '0;
            bitCnt  <= '0;
            bitIdx  <= '0;
            shifter <= '0;
            regAddr <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= stateNext;
            word    <= wordNext;
            byteIdx <= byteIdxNext;
            bitCnt  <= bitCntNext;
            bitIdx  <= bitIdxNext;
            shifter <= shifterNext;
            regAddr <= regAddrNext;
            tx      <= txNext;
            busy    <= busyNext;
            done    <= doneNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext   = state;
        wordNext    = word;
        byteIdxNext = byteIdx;
        bitCntNext  = '0;
        bitIdxNext  = bitIdx;
        shifterNext = shifter;
        regAddrNext = regAddr;
        txNext      = 1'b1;
        busyNext    = busy;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext   = ADDR;
                    regAddrNext = '0;
                    busyNext    = 1'b1;
                end
            end
            ADDR: stateNext = LATCH;
            LATCH: begin
                wordNext    = regData;
                byteIdxNext = '0;
                stateNext   = LOAD;
            end
            LOAD: begin
                // Start bit goes out with the first SHIFT cycle; stop bit rides in the shifter MSB
                shifterNext = {1'b1, frameByte};
                bitIdxNext  = '0;
                txNext      = 1'b0;
                stateNext   = SHIFT;
            end
            SHIFT: begin
                txNext = tx;
                if (bitCnt == BIT_LAST) begin
                    if (bitIdx == BIT_STOP) begin
                        txNext = 1'b1;
                        if (byteIdx == BYTE_LAST) begin
                            stateNext = NEXT;
                        end else begin
                            byteIdxNext = byteIdx + IDX_W'(1);
                            stateNext   = LOAD;
                        end
                    end else begin
                        txNext      = shifter[0];
                        shifterNext = {1'b0, shifter[8:1]};
                        bitIdxNext  = bitIdx + 4'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + CNT_W'(1);
                end
            end
            NEXT: begin
                // busy drops in the same cycle done rises
                if (regAddr == ADDR_LAST) begin
                    stateNext = FIN;
                    doneNext  = 1'b1;
                    busyNext  = 1'b0;
                end else begin
                    regAddrNext = regAddr + ADDR_W'(1);
                    stateNext   = ADDR;
                end
            end
            FIN: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump: table of dump vectors plus hand sequences for held start and reset abort.
module tb_sm_regdump;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned NREGS   = 32;
`ifdef SM_REGDUMP_HEX_EN
    localparam int FPR = 9;
`else
    localparam int FPR = 4;
`endif
    localparam int DUMP_BUDGET = NREGS * FPR * (10 * CLK_DIV + 4) + 200;

    typedef struct {
        logic [31:0] base;
        logic [31:0] mul;
        logic        noise;
        logic [31:0] exp0;
        logic [31:0] exp31;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx, busy, done;

    logic [31:0] dBase = 32'h0;
    logic [31:0] dMul = 32'h0;
    logic        dNoise = 1'b0;

    int nVec = 0;
    int nErr = 0;
    logic [7:0] rxQ[$];
    int frameErr = 0;
    int doneCnt = 0;
    int doneWide = 0;
    logic doneQ = 1'b0;

    sm_regdump #(.CLK_DIV(CLK_DIV), .NREGS(NREGS)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .regAddr(regAddr),
        .regData(regData),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // CPU debug port model; noise corrupts the bus whenever the line is low (mid-frame only)
    always_comb begin
        regData = dBase + dMul * 32'(regAddr);
        if (dNoise && !tx) regData = ~regData;
    end

    // UART receiver sampling mid-bit
    initial begin : rxMon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                if (tx !== 1'b0) frameErr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) frameErr++;
                rxQ.push_back(b);
                repeat (CLK_DIV / 2 - 1) @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        doneQ <= done;
        if (done === 1'b1) doneCnt <= doneCnt + 1;
        if (done === 1'b1 && doneQ === 1'b1) doneWide <= doneWide + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expByte(input logic [31:0] w, input int i);
        logic [31:0] t;
`ifdef SM_REGDUMP_HEX_EN
        logic [3:0] nib;
        if (i == FPR - 1) return 8'h0A;
        t = w >> (28 - 4 * i);
        nib = t[3:0];
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10);
`else
        t = w >> (24 - 8 * i);
        return t[7:0];
`endif
    endfunction

    task automatic waitDone(input string tag);
        bit seen;
        logic prevBusy;
        seen = 1'b0;
        prevBusy = busy;
        for (int c = 0; c < DUMP_BUDGET; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            prevBusy = busy;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            check({tag, "_busy_before_done"}, 32'(prevBusy), 32'd1);
            check({tag, "_last_addr"}, 32'(regAddr), 32'(NREGS - 1));
        end
    endtask

    task automatic checkDump(input string tag, input int q0, input int fe0, input int d0,
                             input logic [31:0] exp0, input logic [31:0] exp31);
        int n;
        logic [31:0] w;
        n = rxQ.size() - q0;
        check({tag, "_frames"}, 32'(n), 32'(NREGS * FPR));
        check({tag, "_frame_errs"}, 32'(frameErr - fe0), 32'd0);
        check({tag, "_done_count"}, 32'(doneCnt - d0), 32'd1);
        check({tag, "_done_wide"}, 32'(doneWide), 32'd0);
        if (n == NREGS * FPR) begin
            for (int k = 0; k < NREGS; k++) begin
                int bad;
                w = (k == 0) ? exp0 : (k == NREGS - 1) ? exp31 : dBase + dMul * 32'(k);
                bad = 0;
                for (int i = FPR - 1; i >= 0; i--)
                    if (rxQ[q0 + k * FPR + i] !== expByte(w, i)) bad = i;
                check($sformatf("%s_word%0d_byte%0d", tag, k, bad),
                      32'(rxQ[q0 + k * FPR + bad]), 32'(expByte(w, bad)));
            end
        end
    endtask

    task automatic runVec(input string tag, input vec_t v);
        int q0, fe0, d0;
        dBase = v.base;
        dMul = v.mul;
        dNoise = v.noise;
        q0 = rxQ.size();
        fe0 = frameErr;
        d0 = doneCnt;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_first_addr"}, 32'(regAddr), 32'd0);
        waitDone(tag);
        repeat (60) @(negedge clk);
        checkDump(tag, q0, fe0, d0, v.exp0, v.exp31);
    endtask

    initial begin
        vec_t vecs[3];
        int q0, fe0, d0;
        bit hit;
        vecs[0] = '{32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 32'h12345678};
        vecs[1] = '{32'h00000000, 32'h00000003, 1'b0, 32'h00000000, 32'h0000005D};
        vecs[2] = '{32'h0000ABCD, 32'h01000001, 1'b1, 32'h0000ABCD, 32'h1F00ABEC};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(regAddr), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_wait_busy", 32'(busy), 32'd0);
        check("idle_wait_tx", 32'(tx), 32'd1);

        for (int v = 0; v < 3; v++) runVec($sformatf("vec%0d", v), vecs[v]);

        // start held high across the whole dump gives a single dump
        dBase = vecs[0].base;
        dMul = vecs[0].mul;
        dNoise = 1'b0;
        q0 = rxQ.size();
        fe0 = frameErr;
        d0 = doneCnt;
        start = 1'b1;
        waitDone("held");
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        checkDump("held", q0, fe0, d0, vecs[0].exp0, vecs[0].exp31);
        runVec("held_again", vecs[0]);

        // Reset in the middle of data bit 3 of the second frame
        q0 = rxQ.size();
        d0 = doneCnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (rxQ.size() > q0) hit = 1'b1;
        end
        check("abort_first_frame", 32'(hit), 32'd1);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (tx === 1'b0) hit = 1'b1;
        end
        check("abort_second_start", 32'(hit), 32'd1);
        repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(regAddr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_done", 32'(doneCnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        runVec("after_abort", vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/sm_regdump.md
SM_REGDUMP -- requirements
Module: sm_regdump

Interface
REQ-001 Parameter CLK_DIV, default 434, SHALL set the clocks per UART bit; legal range 2..65535.
REQ-002 Parameter NREGS, default 32, SHALL set the count of debug addresses dumped, from 0 to NREGS-1; legal range 1..32.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be an asynchronous active-low reset.
REQ-005 Port start, input, 1, SHALL request a dump when high for one or more cycles in IDLE.
REQ-006 Port regAddr, output, 5, SHALL drive the CPU debug read address; address 0 returns the PC.
REQ-007 Port regData, input, 32, SHALL carry the CPU debug read data, combinational from regAddr.
REQ-008 Port tx, output, 1, SHALL be the UART serial line, 8N1, idle high.
REQ-009 Port busy, output, 1, SHALL be high from the cycle after start is accepted until done.
REQ-010 Port done, output, 1, SHALL pulse high for exactly one cycle after the last stop bit of the dump.

Function
REQ-011 FSM states SHALL be IDLE, ADDR, LATCH, LOAD, SHIFT, NEXT, FIN.
REQ-012 IDLE->ADDR on start=1; regAddr<=0; busy<=1.
REQ-013 ADDR SHALL hold regAddr stable for one cycle; ADDR->LATCH.
REQ-014 LATCH SHALL capture regData into a 32-bit word register; byte index<=0; LATCH->LOAD.
REQ-015 LOAD SHALL place the next byte of the captured word in the shifter; LOAD->SHIFT.
REQ-016 SHIFT SHALL send start bit 0, data bits LSB first, then stop bit 1; each bit lasts exactly CLK_DIV cycles; a frame lasts 10*CLK_DIV cycles.
REQ-017 After each frame: if more bytes remain for the word, SHIFT->LOAD; otherwise SHIFT->NEXT.
REQ-018 In NEXT: if regAddr==NREGS-1, NEXT->FIN; otherwise regAddr increments by 1 and NEXT->ADDR.
REQ-019 In FIN: done=1 for one cycle, busy<=0; FIN->IDLE.
REQ-020 start SHALL be ignored while busy=1; a new dump needs start high in IDLE.
REQ-021 The bit counter SHALL count 0..CLK_DIV-1 and wrap; it SHALL be held at 0 outside SHIFT.
REQ-022 The captured word SHALL not change during its frames, even if regData changes.
REQ-023 Back-to-back frames SHALL be separated only by the LOAD cycle, or by NEXT/ADDR/LATCH/LOAD between registers; tx SHALL stay 1 in those gap cycles.

Reset
REQ-024 With rst_n=0, state SHALL go to IDLE at once, with tx=1, regAddr=0, busy=0, done=0, and all counters and shifters 0.
REQ-025 Reset during a frame SHALL abort it at once; tx SHALL go high without finishing the frame; no done pulse.
REQ-026 After rst_n is released, the block SHALL wait in IDLE for start.

Configuration
REQ-027 Macro SM_REGDUMP_HEX_EN defined: each register SHALL be sent as 8 ASCII hex characters, MSB nibble first, uppercase 0-9/A-F, then 0x0A; 9 frames per register.
REQ-028 Macro SM_REGDUMP_HEX_EN undefined: each register SHALL be sent as 4 raw bytes, most significant byte first; 4 frames per register.

Verification
REQ-029 Raw mode, CLK_DIV=4, NREGS=1, regData=0x12345678, pulse start -> tx shows bytes 0x12,0x34,0x56,0x78; each frame 40 cycles; done pulses once; busy falls the same cycle.
REQ-030 HEX_EN mode, CLK_DIV=4, NREGS=2, regData=0x0000ABCD for all addresses -> 18 frames: "0000ABCD\n" twice; regAddr steps 0 then 1.
REQ-031 Raw mode, CLK_DIV=4, NREGS=32, regData=address*3 model -> 128 frames; word k decodes to 3k; final regAddr=31; one done.
REQ-032 start held high for the whole dump, CLK_DIV=4, NREGS=1 -> exactly one dump; a second start pulse after done -> a second identical dump.
REQ-033 rst_n driven low in mid data bit 3 of frame 2 -> tx=1, busy=0, regAddr=0 in the same cycle; no done; a later start dumps from address 0.
REQ-034 regData changed during the frames of a word, raw mode -> transmitted bytes match the value captured in LATCH.
